softmax_input_buffer: RTL and testbench

On-chip vector store and launcher that sits in front of the softmax core and serves its memory side.
- Accepts a valid/ready stream of packed NUM-lane vectors and writes them at consecutive addresses.
- Drives the core's init/start/start_addr/end_addr and answers its three independent read-address ports (max, first-stage sub, second-stage sub) with zero-latency read data.
- Waits for the core's done to fall, then pulses complete and returns to accepting the next vector set.

---
 rtl/softmax_input_buffer.sv | 187 ++++++++++++++++++
 tb/tb_softmax_input_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : softmax_input_buffer
// Purpose  : Vector store in front of the softmax core. Loads a valid/ready
//            stream of packed NUM-lane vectors at consecutive addresses,
//            launches the core (init/start), serves its three combinational
//            read ports and pulses complete once the core's done falls.
// Option   : SMX_BUF_RANGE_CHECK_EN - gate reads outside [start_addr,end_addr)
//            or while loading to zero and keep a sticky range_err flag.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_input_buffer #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 4,
  parameter int ADDRSIZE  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRSIZE-1:0]      base_addr,
  input  logic [DATAWIDTH*NUM-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [ADDRSIZE-1:0]      start_addr,
  output logic [ADDRSIZE-1:0]      end_addr,
  output logic                     init,
  output logic                     start,
  input  logic                     done,
  input  logic [ADDRSIZE-1:0]      addr,
  input  logic [ADDRSIZE-1:0]      sub0_inp_addr,
  input  logic [ADDRSIZE-1:0]      sub1_inp_addr,
  output logic [DATAWIDTH*NUM-1:0] inp,
  output logic [DATAWIDTH*NUM-1:0] sub0_inp,
  output logic [DATAWIDTH*NUM-1:0] sub1_inp,
  output logic                     busy,
  output logic                     complete,
  output logic                     overflow
);

  localparam int W     = DATAWIDTH * NUM;
  localparam int DEPTH = 2 ** ADDRSIZE;
  // Highest address a beat may occupy; storing here forces the set to end so
  // end_addr (one past) still fits in ADDRSIZE bits.
  localparam logic [ADDRSIZE-1:0] ADDR_FULL    = {{(ADDRSIZE-1){1'b1}}, 1'b0};
  // A set may not begin here: its end_addr would wrap to zero.
  localparam logic [ADDRSIZE-1:0] ADDR_ILLEGAL = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    INIT   = 3'd2,
    START  = 3'd3,
    RUN    = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t              state;
  logic [ADDRSIZE-1:0] wr_ptr;
  logic                done_q;
  logic [W-1:0]        mem [DEPTH];

  logic                in_idle;
  logic                accept;
  logic                base_bad;
  logic                wr_en;
  logic [ADDRSIZE-1:0] wr_addr;
  logic [ADDRSIZE-1:0] next_ptr;
  logic                last_beat;

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign busy      = (state != IDLE);
  assign in_idle   = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign wr_addr   = in_idle ? base_addr : wr_ptr;
  assign base_bad  = in_idle && (base_addr == ADDR_ILLEGAL);
  assign wr_en     = accept & ~base_bad;
  assign next_ptr  = wr_addr + 1'b1;
  assign last_beat = in_last | (wr_addr == ADDR_FULL);

  // Vector storage: written on each legal accepted beat, never cleared.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wr_addr] <= in_data;
  end

  // Control FSM: load, launch the core, wait for done to fall, report.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      start_addr <= '0;
      end_addr   <= '0;
      init       <= 1'b0;
      start      <= 1'b0;
      complete   <= 1'b0;
      overflow   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      init     <= 1'b0;
      start    <= 1'b0;
      complete <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (base_bad) begin
              overflow <= 1'b1;
            end else begin
              start_addr <= base_addr;
              wr_ptr     <= next_ptr;
              overflow   <= ~in_last & (base_addr == ADDR_FULL);
              if (last_beat) begin
                state    <= INIT;
                init     <= 1'b1;
                end_addr <= next_ptr;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_ptr <= next_ptr;
            if (last_beat) begin
              state    <= INIT;
              init     <= 1'b1;
              end_addr <= next_ptr;
              if (!in_last) overflow <= 1'b1;
            end
          end
        end
        INIT: begin
          start <= 1'b1;
          state <= START;
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          done_q <= done;
          if (done_q && !done) begin
            state    <= FINISH;
            complete <= 1'b1;
          end
        end
        FINISH: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SMX_BUF_RANGE_CHECK_EN
  logic window_open;
  logic ok_max;
  logic ok_sub0;
  logic ok_sub1;
  logic range_err;

  assign window_open = (state != IDLE) && (state != LOAD);
  assign ok_max  = window_open && (addr >= start_addr) && (addr < end_addr);
  assign ok_sub0 = window_open && (sub0_inp_addr >= start_addr) && (sub0_inp_addr < end_addr);
  assign ok_sub1 = window_open && (sub1_inp_addr >= start_addr) && (sub1_inp_addr < end_addr);

  assign inp      = ok_max  ? mem[addr]          : '0;
  assign sub0_inp = ok_sub0 ? mem[sub0_inp_addr] : '0;
  assign sub1_inp = ok_sub1 ? mem[sub1_inp_addr] : '0;

  // Sticky out-of-range flag, cleared when a new set begins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      range_err <= 1'b0;
    end else if (in_idle && accept) begin
      range_err <= 1'b0;
    end else if ((state == RUN) && !(ok_max && ok_sub0 && ok_sub1)) begin
      range_err <= 1'b1;
    end
  end
`else
  assign inp      = mem[addr];
  assign sub0_inp = mem[sub0_inp_addr];
  assign sub1_inp = mem[sub1_inp_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_softmax_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_input_buffer
// Purpose  : Self-checking bench for softmax_input_buffer: table-driven vector
//            sets, randomized sets against a memory model, and hand sequences
//            for the illegal base address and reset during a run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_input_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  base_addr;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  start_addr;
  logic [7:0]  end_addr;
  logic        init;
  logic        start;
  logic        done;
  logic [7:0]  addr;
  logic [7:0]  sub0_inp_addr;
  logic [7:0]  sub1_inp_addr;
  logic [63:0] inp;
  logic [63:0] sub0_inp;
  logic [63:0] sub1_inp;
  logic        busy;
  logic        complete;
  logic        overflow;

  softmax_input_buffer #(.DATAWIDTH(16), .NUM(4), .ADDRSIZE(8)) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .start_addr(start_addr), .end_addr(end_addr), .init(init), .start(start),
    .done(done), .addr(addr), .sub0_inp_addr(sub0_inp_addr),
    .sub1_inp_addr(sub1_inp_addr), .inp(inp), .sub0_inp(sub0_inp),
    .sub1_inp(sub1_inp), .busy(busy), .complete(complete), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] model_mem [256];

  typedef struct {
    logic [7:0] base;
    int         nbeats;
    int         last_idx;   // -1: no beat carries in_last
    int         gap;        // idle cycles between beats
    logic [7:0] exp_end;
    logic       exp_ovf;
    int         exp_cnt;    // beats expected to be accepted
  } set_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int s, input int i);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) v[16*j +: 16] = 16'((s << 12) | ((i + 1) << 8) | j);
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Loads one set, checks launch timing, acts as the core, checks completion.
  task automatic run_set(input int s, input logic [7:0] base, input int nbeats,
                         input int last_idx, input int gap, input logic [7:0] exp_end,
                         input logic exp_ovf, input int exp_cnt, input bit rnd,
                         input bit abort);
    logic [7:0] a;
    logic [7:0] prev_a;
    bit         have_prev;
    bit         accepted;
    int         guard;
    int         g;
    a = base;
    prev_a = '0;
    have_prev = 0;
    for (int i = 0; i < exp_cnt; i++) begin
      g = rnd ? $urandom_range(0, 2) : gap;
      if (i > 0) begin
        for (int k = 0; k < g; k++) begin
          cyc();
          in_valid = 1'b0;
          in_data  = {$urandom, $urandom};
          @(negedge clk);
          chk("load_hold_busy", 64'(busy), 64'(1));
        end
      end
      accepted = 0;
      guard = 0;
      while (!accepted) begin
        cyc();
        base_addr = base;
        in_valid  = 1'b1;
        in_last   = (i == last_idx);
        in_data   = rnd ? {$urandom, $urandom} : pat(s, i);
        if (have_prev) addr = prev_a;
        @(negedge clk);
`ifndef SMX_BUF_RANGE_CHECK_EN
        if (have_prev) chk("read_after_write", inp, model_mem[prev_a]);
`endif
        if (in_ready) accepted = 1;
        else begin
          guard++;
          if (guard > 20) begin
            chk("accept_timeout", 64'(0), 64'(1));
            in_valid = 1'b0;
            return;
          end
        end
      end
      model_mem[a] = in_data;
      prev_a = a;
      have_prev = 1;
      a = a + 8'd1;
    end
    // INIT cycle: an extra beat, if offered, must be refused.
    cyc();
    if (nbeats > exp_cnt) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    end else in_valid = 1'b0;
    @(negedge clk);
    chk("init_pulse", 64'(init), 64'(1));
    chk("init_no_start", 64'(start), 64'(0));
    chk("start_addr", 64'(start_addr), 64'(base));
    chk("end_addr", 64'(end_addr), 64'(exp_end));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    chk("init_ready_low", 64'(in_ready), 64'(0));
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("start_pulse", 64'(start), 64'(1));
    chk("start_no_init", 64'(init), 64'(0));
    // RUN with done low: must hold.
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk("run_hold_busy", 64'(busy), 64'(1));
      chk("run_no_complete", 64'(complete | start | init), 64'(0));
    end
    // Core busy: done high while reading.
    for (int k = 0; k < 4; k++) begin
      cyc();
      done = 1'b1;
      if (k == 0) begin
        addr          = (exp_cnt > 1) ? base + 8'd1 : base;
        sub0_inp_addr = addr;
        sub1_inp_addr = exp_end - 8'd1;
      end else begin
        addr          = base + 8'($urandom_range(0, exp_cnt - 1));
        sub0_inp_addr = base + 8'($urandom_range(0, exp_cnt - 1));
        sub1_inp_addr = base + 8'($urandom_range(0, exp_cnt - 1));
      end
      @(negedge clk);
      chk("inp", inp, model_mem[addr]);
      chk("sub0_inp", sub0_inp, model_mem[sub0_inp_addr]);
      chk("sub1_inp", sub1_inp, model_mem[sub1_inp_addr]);
    end
    if (abort) begin
      cyc();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      done  = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_ready", 64'(in_ready), 64'(1));
      chk("abort_start_addr", 64'(start_addr), 64'(0));
      chk("abort_end_addr", 64'(end_addr), 64'(0));
      for (int k = 0; k < 3; k++) begin
        cyc();
        @(negedge clk);
        chk("abort_no_complete", 64'(complete), 64'(0));
      end
      return;
    end
    cyc();
    done = 1'b0;
    @(negedge clk);
    chk("complete_not_early", 64'(complete), 64'(0));
    cyc();
    @(negedge clk);
    chk("complete_pulse", 64'(complete), 64'(1));
    chk("finish_ready_low", 64'(in_ready), 64'(0));
    cyc();
    @(negedge clk);
    chk("complete_single", 64'(complete), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_ready", 64'(in_ready), 64'(1));
    chk("stable_end_addr", 64'(end_addr), 64'(exp_end));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_t tbl [7];
    int len;
    logic [7:0] b;

    tbl[0] = '{8'h10, 4, 3, 0, 8'h14, 1'b0, 4};
    tbl[1] = '{8'h00, 1, 0, 0, 8'h01, 1'b0, 1};
    tbl[2] = '{8'h40, 6, 5, 1, 8'h46, 1'b0, 6};
    tbl[3] = '{8'hFC, 5, -1, 0, 8'hFF, 1'b1, 3};
    tbl[4] = '{8'h30, 2, 1, 0, 8'h32, 1'b0, 2};
    tbl[5] = '{8'hFE, 1, 0, 0, 8'hFF, 1'b0, 1};
    tbl[6] = '{8'hFE, 2, -1, 0, 8'hFF, 1'b1, 1};

    reset = 1'b0; base_addr = '0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    done = 1'b0; addr = '0; sub0_inp_addr = '0; sub1_inp_addr = '0;
    repeat (3) cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_start_addr", 64'(start_addr), 64'(0));
    chk("rst_end_addr", 64'(end_addr), 64'(0));
    chk("rst_pulses", 64'({init, start, complete, overflow}), 64'(0));

    for (int t = 0; t < 7; t++)
      run_set(t, tbl[t].base, tbl[t].nbeats, tbl[t].last_idx, tbl[t].gap,
              tbl[t].exp_end, tbl[t].exp_ovf, tbl[t].exp_cnt, 0, 0);

    // Illegal base address: beat dropped, overflow flagged, stay idle.
    cyc();
    base_addr = 8'hFF; in_valid = 1'b1; in_last = 1'b1; in_data = 64'h1234;
    @(negedge clk);
    chk("bad_base_ready", 64'(in_ready), 64'(1));
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bad_base_ovf", 64'(overflow), 64'(1));
    chk("bad_base_idle", 64'(busy | init), 64'(0));

    // Randomized sets against the memory model.
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 8);
      b   = 8'($urandom_range(0, 240));
      run_set(8 + r, b, len, len - 1, 0, b + 8'(len), 1'b0, len, 1, 0);
    end

    // Reset during RUN with done high, then a normal set.
    run_set(20, 8'h60, 3, 2, 0, 8'h63, 1'b0, 3, 0, 1);
    run_set(21, 8'h70, 2, 1, 0, 8'h72, 1'b0, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
